muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the MIPS MULT/MULTU/DIV/DIVU instructions.
- Drives one shared 33-bit add/subtract datapath for both operations: shift-add for multiply, restoring subtract for divide.
- Sits beside the EX stage. The pipeline stalls on busy, and the HI/LO registers are read from this block's outputs.

---
 rtl/muldiv_seq.sv | 99 +++++++++
 tb/tb_muldiv_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MIPS MULT/MULTU/DIV/DIVU sequencer on one shared 33-bit add/sub datapath.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
  state_t                    r_state;
  logic [1:0]                r_op;
  logic [XLEN-1:0]           r_a, r_b, r_m, r_hi, r_lo;
  logic                      r_neg_q, r_neg_r;
  logic [$clog2(XLEN)-1:0]   r_cnt;
  logic                      w_mul, w_sgn, w_sub, w_dbz;
  logic [XLEN-1:0]           w_abs_a, w_abs_b, w_q, w_r;
  logic [XLEN:0]             w_x, w_y, w_sum;
  logic [2*XLEN-1:0]         w_prod;
  always_comb begin
    w_mul   = ~r_op[1];
    w_sgn   = r_op[0];
    w_sub   = ~w_mul;
    w_abs_a = (w_sgn & r_a[XLEN-1]) ? -r_a : r_a;
    w_abs_b = (w_sgn & r_b[XLEN-1]) ? -r_b : r_b;
    // multiply adds the multiplicand into the upper half; divide subtracts the divisor from the shifted remainder
    w_x     = w_mul ? {1'b0, r_hi} : {r_hi, r_lo[XLEN-1]};
    w_y     = (w_mul & ~r_lo[0]) ? '0 : {1'b0, r_m};
    w_sum   = w_x + (w_sub ? ~w_y : w_y) + (XLEN+1)'(w_sub);
    w_prod  = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_q     = r_neg_q ? -r_lo : r_lo;
    w_r     = r_neg_r ? -r_hi : r_hi;
    w_dbz   = w_sub & (r_b == '0);
  end
  assign busy = (r_state != IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_m         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_cnt       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_op    <= op;
          r_a     <= a;
          r_b     <= b;
          r_state <= PREP;
        end
        PREP: begin
          r_m     <= w_mul ? w_abs_a : w_abs_b;
          r_lo    <= w_mul ? w_abs_b : w_abs_a;
          r_hi    <= '0;
          r_neg_q <= w_sgn & (r_a[XLEN-1] ^ r_b[XLEN-1]);
          r_neg_r <= w_sgn & r_a[XLEN-1];
          r_cnt   <= '0;
          r_state <= CALC;
        end
        CALC: begin
          if (w_mul) begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end else begin
            r_hi <= w_sum[XLEN] ? w_x[XLEN-1:0] : w_sum[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], ~w_sum[XLEN]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == ($clog2(XLEN))'(XLEN-1)) r_state <= FIX;
        end
        FIX: begin
          hi          <= w_mul ? w_prod[2*XLEN-1:XLEN] : (w_dbz ? r_a : w_r);
          lo          <= w_mul ? w_prod[XLEN-1:0] : (w_dbz ? '1 : w_q);
          div_by_zero <= w_dbz;
          done        <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst, start, busy, done, div_by_zero;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic [1:0]  cur_op;
  logic [31:0] cur_a, cur_b;
  int          n_cmp = 0;
  int          n_bad = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] eh, output logic [31:0] el, output logic ed);
    logic [63:0] p;
    longint      sx, sy, q, r;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ed = 1'b0;
    if (o == 2'd0) p = {32'b0, x} * {32'b0, y};
    else if (o == 2'd1) p = 64'(sx * sy);
    else if (y == 0) begin
      p  = {x, 32'hFFFF_FFFF};
      ed = 1'b1;
    end else if (o == 2'd2) p = {x % y, x / y};
    else begin
      q = sx / sy;
      r = sx % sy;
      p = {r[31:0], q[31:0]};
    end
    eh = p[63:32];
    el = p[31:0];
  endfunction

  task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    cur_op = o; cur_a = x; cur_b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in cycle 1; scrambles inputs while busy and optionally pulses a stray start at cycle inj.
  task automatic wait_done(input string tag, input int inj);
    int n, bb;
    logic [31:0] eh, el;
    logic        ed;
    n = 1;
    bb = 0;
    while (!done && n < 100) begin
      if (n <= 34 && !busy) bb++;
      if (n == inj) begin
        start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    ref_model(cur_op, cur_a, cur_b, eh, el, ed);
    chk({tag, ".lat"}, 64'(n), 64'd35);
    chk({tag, ".busy_run"}, 64'(bb), 64'd0);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".lo"}, 64'(lo), 64'(el));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ed));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    cur_op = '0; cur_a = '0; cur_b = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.dbz", 64'(div_by_zero), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    go(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("multu_max", 0);
    chk("multu_max.hi_k", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max.lo_k", 64'(lo), 64'h1);
    @(negedge clk);
    chk("hold.done", 64'(done), 64'd0);
    chk("hold.hi", 64'(hi), 64'hFFFF_FFFE);
    go(2'd1, 32'hFFFF_FFFD, 32'd5);         wait_done("mult_neg", 0);
    go(2'd3, 32'hFFFF_FFF9, 32'd2);         wait_done("div_neg", 0);
    chk("div_neg.lo_k", 64'(lo), 64'hFFFF_FFFD);
    go(2'd2, 32'd100, 32'd0);               wait_done("divu_zero", 0);
    chk("divu_zero.hi_k", 64'(hi), 64'd100);
    go(2'd0, 32'd3, 32'd4);                 wait_done("multu_after_dbz", 0);
    go(2'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", 0);
    chk("div_ovf.lo_k", 64'(lo), 64'h8000_0000);
    go(2'd3, 32'h8000_0003, 32'd0);         wait_done("div_zero", 0);

    go(2'd0, 32'd2, 32'd3);                 wait_done("haz_ignored", 10);
    chk("haz_ignored.lo_k", 64'(lo), 64'd6);
    go(2'd2, 32'd9, 32'd3);                 wait_done("reissue", 0);
    chk("reissue.lo_k", 64'(lo), 64'd3);

    go(2'd2, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.hi", 64'(hi), 64'd0);
    chk("abort.lo", 64'(lo), 64'd0);
    nd = 0;
    repeat (50) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort.no_done", 64'(nd), 64'd0);
    go(2'd2, 32'd100, 32'd7);               wait_done("after_rst", 0);
    chk("after_rst.lo_k", 64'(lo), 64'd14);
    chk("after_rst.hi_k", 64'(hi), 64'd2);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      go(2'($urandom), pick(), pick());
      wait_done($sformatf("rnd%0d", i), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
